// File: rtl/pwm_cfg_sequencer.sv
// pwm_cfg_sequencer
//   Decodes the SPI byte stream into 16-bit freq/duty reads and writes for
//   N_CH PWM channels. Writes land in a staged bank and are copied to the
//   active bank at each channel's period boundary, so a PWM never sees a
//   half-updated configuration.
// Ports
//   clk, rst            clock, async active-high reset
//   ss                  SPI slave select, active low
//   rx_byte_available   byte-valid level; a byte is taken on its rising edge
//   rx_byte             received byte
//   tx_byte             byte returned on the next SPI transfer
//   period_end          per-channel end-of-period pulse from the PWMs
//   freq_bus, duty_bus  active registers, channel k at [16k+15:16k]
//   cfg_update          per-channel pulse when active registers change
//   cmd_error           pulse on access to a channel >= N_CH
module pwm_cfg_sequencer #(
   parameter int unsigned N_CH     = 4,
   parameter logic [15:0] FREQ_RST = 16'd490,
   parameter logic [15:0] DUTY_RST = 16'd1250
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ss,
   input  logic                 rx_byte_available,
   input  logic [7:0]           rx_byte,
   output logic [7:0]           tx_byte,
   input  logic [N_CH-1:0]      period_end,
   output logic [16*N_CH-1:0]   freq_bus,
   output logic [16*N_CH-1:0]   duty_bus,
   output logic [N_CH-1:0]      cfg_update,
   output logic                 cmd_error
);

   typedef enum logic [1:0] {IDLE, LO, HI} state_t;

   state_t            state_q, state_d;
   logic              rx_avail_q, rx_avail_d;
   logic [3:0]        ch_q, ch_d;
   logic              sel_q, sel_d;
   logic              wr_q, wr_d;
   logic [7:0]        lo_q, lo_d;
   logic [7:0]        tx_byte_q, tx_byte_d;
   logic [N_CH-1:0]   cfg_update_q, cfg_update_d;
   logic              cmd_error_q, cmd_error_d;
   logic [N_CH-1:0]   pend_freq_q, pend_freq_d;
   logic [N_CH-1:0]   pend_duty_q, pend_duty_d;
   logic [15:0]       stg_freq_q [N_CH];
   logic [15:0]       stg_freq_d [N_CH];
   logic [15:0]       stg_duty_q [N_CH];
   logic [15:0]       stg_duty_d [N_CH];
   logic [15:0]       act_freq_q [N_CH];
   logic [15:0]       act_freq_d [N_CH];
   logic [15:0]       act_duty_q [N_CH];
   logic [15:0]       act_duty_d [N_CH];

   logic              rx_stb;
   logic              ch_valid;
   logic [3:0]        rd_ch;
   logic              rd_sel;
   logic [15:0]       rd_val;
   logic [N_CH-1:0]   commit;

   always_comb begin
      state_d      = state_q;
      rx_avail_d   = rx_byte_available;
      ch_d         = ch_q;
      sel_d        = sel_q;
      wr_d         = wr_q;
      lo_d         = lo_q;
      tx_byte_d    = tx_byte_q;
      cfg_update_d = '0;
      cmd_error_d  = 1'b0;
      pend_freq_d  = pend_freq_q;
      pend_duty_d  = pend_duty_q;
      stg_freq_d   = stg_freq_q;
      stg_duty_d   = stg_duty_q;
      act_freq_d   = act_freq_q;
      act_duty_d   = act_duty_q;
      commit       = '0;

      rx_stb   = rx_byte_available & ~rx_avail_q;
      ch_valid = ({1'b0, ch_q} < 5'(N_CH));

      // Staged word that feeds tx_byte: the incoming command's channel in
      // IDLE, the current channel in LO, the next (wrapping) channel in HI.
      case (state_q)
         IDLE:    begin rd_ch = rx_byte[3:0]; rd_sel = rx_byte[4]; end
         LO:      begin rd_ch = ch_q;         rd_sel = sel_q;      end
         default: begin rd_ch = ch_q + 4'd1;  rd_sel = sel_q;      end
      endcase
      rd_val = '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         if (rd_ch == 4'(k)) rd_val = rd_sel ? stg_duty_q[k] : stg_freq_q[k];
      end

      if (ss) begin
         state_d = IDLE;
      end else if (rx_stb) begin
         case (state_q)
            IDLE: begin
               ch_d      = rx_byte[3:0];
               sel_d     = rx_byte[4];
               wr_d      = rx_byte[5];
               tx_byte_d = rd_val[7:0];
               state_d   = LO;
            end
            LO: begin
               lo_d      = rx_byte;
               tx_byte_d = rd_val[15:8];
               state_d   = HI;
            end
            default: begin
               if (!ch_valid) begin
                  cmd_error_d = 1'b1;
               end else if (wr_q) begin
                  for (int unsigned k = 0; k < N_CH; k++) begin
                     if (ch_q == 4'(k)) begin
                        commit[k] = 1'b1;
                        if (sel_q) begin
                           stg_duty_d[k]  = {rx_byte, lo_q};
                           pend_duty_d[k] = 1'b1;
                        end else begin
                           stg_freq_d[k]  = {rx_byte, lo_q};
                           pend_freq_d[k] = 1'b1;
                        end
                     end
                  end
               end
               ch_d      = ch_q + 4'd1;
               tx_byte_d = rd_val[7:0];
               state_d   = LO;
            end
         endcase
      end

      // A same-cycle commit blocks the apply so the new word is not lost;
      // pend stays set and the next period_end picks it up.
      for (int unsigned k = 0; k < N_CH; k++) begin
         if (period_end[k] && (pend_freq_q[k] || pend_duty_q[k]) && !commit[k]) begin
            act_freq_d[k]   = stg_freq_q[k];
            act_duty_d[k]   = stg_duty_q[k];
            pend_freq_d[k]  = 1'b0;
            pend_duty_d[k]  = 1'b0;
            cfg_update_d[k] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         rx_avail_q   <= 1'b0;
         ch_q         <= '0;
         sel_q        <= 1'b0;
         wr_q         <= 1'b0;
         lo_q         <= '0;
         tx_byte_q    <= '0;
         cfg_update_q <= '0;
         cmd_error_q  <= 1'b0;
         pend_freq_q  <= '0;
         pend_duty_q  <= '0;
         for (int unsigned k = 0; k < N_CH; k++) begin
            stg_freq_q[k] <= FREQ_RST;
            stg_duty_q[k] <= DUTY_RST;
            act_freq_q[k] <= FREQ_RST;
            act_duty_q[k] <= DUTY_RST;
         end
      end else begin
         state_q      <= state_d;
         rx_avail_q   <= rx_avail_d;
         ch_q         <= ch_d;
         sel_q        <= sel_d;
         wr_q         <= wr_d;
         lo_q         <= lo_d;
         tx_byte_q    <= tx_byte_d;
         cfg_update_q <= cfg_update_d;
         cmd_error_q  <= cmd_error_d;
         pend_freq_q  <= pend_freq_d;
         pend_duty_q  <= pend_duty_d;
         stg_freq_q   <= stg_freq_d;
         stg_duty_q   <= stg_duty_d;
         act_freq_q   <= act_freq_d;
         act_duty_q   <= act_duty_d;
      end
   end

   always_comb begin
      freq_bus = '0;
      duty_bus = '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         freq_bus[16*k +: 16] = act_freq_q[k];
         duty_bus[16*k +: 16] = act_duty_q[k];
      end
   end

   assign tx_byte    = tx_byte_q;
   assign cfg_update = cfg_update_q;
   assign cmd_error  = cmd_error_q;

endmodule
